// File: rtl/packet_receiver_pkg.sv
// Shared packet-format constants and receive FSM state encoding,
// common to packet_receiver and packet_sender.
package packet_receiver_pkg;

    localparam int IDX_SRC  = 0;
    localparam int IDX_DST  = 1;
    localparam int IDX_SIZE = 2;
    localparam int IDX_DATA = 3;

    localparam int SIZE_BITS = 3;
    localparam logic [SIZE_BITS-1:0] SIZE_MASK = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DST  = 3'd1,
        ST_SIZE = 3'd2,
        ST_DATA = 3'd3,
        ST_CRC  = 3'd4,
        ST_DROP = 3'd5
    } pkt_state_e;

endpackage

// File: rtl/packet_receiver_crc.sv
// Running XOR check-byte accumulator: load on SRC, fold in header/data bytes,
// compare against the received check byte.
module pkt_crc_acc #(
    parameter int UWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              acc_i,
    input  logic [UWIDTH-1:0] byte_i,
    output logic              match_o
);

    logic [UWIDTH-1:0] crc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
        end else if (load_i) begin
            crc_q <= byte_i;
        end else if (acc_i) begin
            crc_q <= crc_q ^ byte_i;
        end
    end

    assign match_o = (crc_q == byte_i);

endmodule

// File: rtl/packet_receiver.sv
// Packet receiver: parses SRC/DST/SIZE/DATA/CRC byte stream into a buffer slot,
// committing with winc on a good check byte and flagging crc/truncation/drop events.
module packet_receiver #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 packet_valid,
    input  logic [UWIDTH-1:0]    packet_in,
    input  logic                 wfull,
    output logic                 we,
    output logic [PTR_IN_SZ-1:0] waddr_out,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 winc,
    output logic                 crc_err,
    output logic                 trunc_err,
    output logic                 drop
);

    import packet_receiver_pkg::*;

    pkt_state_e           state_q;
    logic [SIZE_BITS-1:0] cnt_q;
    logic                 we_q;
    logic [PTR_IN_SZ-1:0] waddr_q;
    logic [UWIDTH-1:0]    wdata_q;
    logic                 winc_q;
    logic                 crc_err_q;
    logic                 trunc_err_q;
    logic                 drop_q;

    logic crc_load;
    logic crc_acc;
    logic crc_match;

    // The check byte itself is never folded in, so the compare in CRC sees SRC..DATA only.
    assign crc_load = (state_q == ST_IDLE) && packet_valid && !wfull;
    assign crc_acc  = packet_valid &&
                      ((state_q == ST_DST) || (state_q == ST_SIZE) || (state_q == ST_DATA));

    pkt_crc_acc #(.UWIDTH(UWIDTH)) u_crc (
        .clk     (clk),
        .rst     (rst),
        .load_i  (crc_load),
        .acc_i   (crc_acc),
        .byte_i  (packet_in),
        .match_o (crc_match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            winc_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            we_q        <= 1'b0;
            winc_q      <= 1'b0;
            crc_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
            drop_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (packet_valid) begin
                        if (wfull) begin
                            drop_q  <= 1'b1;
                            state_q <= ST_DROP;
                        end else begin
                            we_q    <= 1'b1;
                            waddr_q <= PTR_IN_SZ'(IDX_SRC);
                            wdata_q <= packet_in;
                            state_q <= ST_DST;
                        end
                    end
                end
                ST_DROP: begin
                    if (!packet_valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DST, ST_SIZE, ST_DATA, ST_CRC: begin
                    if (!packet_valid) begin
                        trunc_err_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        we_q    <= 1'b1;
                        wdata_q <= packet_in;
                        case (state_q)
                            ST_DST: begin
                                waddr_q <= PTR_IN_SZ'(IDX_DST);
                                state_q <= ST_SIZE;
                            end
                            ST_SIZE: begin
                                waddr_q <= PTR_IN_SZ'(IDX_SIZE);
                                cnt_q   <= packet_in[SIZE_BITS-1:0] & SIZE_MASK;
                                state_q <= ST_DATA;
                            end
                            ST_DATA: begin
                                waddr_q <= waddr_q + 1'b1;
                                if (cnt_q != '0) begin
                                    cnt_q <= cnt_q - 1'b1;
                                end else begin
                                    state_q <= ST_CRC;
                                end
                            end
                            ST_CRC: begin
                                waddr_q <= waddr_q + 1'b1;
                                if (crc_match) begin
                                    winc_q <= 1'b1;
                                end else begin
                                    crc_err_q <= 1'b1;
                                end
                                state_q <= ST_IDLE;
                            end
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign we        = we_q;
    assign waddr_out = waddr_q;
    assign wdata     = wdata_q;
    assign winc      = winc_q;
    assign crc_err   = crc_err_q;
    assign trunc_err = trunc_err_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_packet_receiver.sv
// Bench for packet_receiver: directed and randomized byte streams checked
// cycle by cycle against a packet-level reference model.
module tb_packet_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       packet_valid = 1'b0;
    logic [7:0] packet_in = 8'h00;
    logic       wfull = 1'b0;
    logic       we, winc, crc_err, trunc_err, drop;
    logic [3:0] waddr_out;
    logic [7:0] wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    packet_receiver #(.UWIDTH(8), .PTR_IN_SZ(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .packet_valid (packet_valid),
        .packet_in    (packet_in),
        .wfull        (wfull),
        .we           (we),
        .waddr_out    (waddr_out),
        .wdata        (wdata),
        .winc         (winc),
        .crc_err      (crc_err),
        .trunc_err    (trunc_err),
        .drop         (drop)
    );

    // Reference model: tracks position within the current packet and its total length.
    bit         m_in_pkt;
    bit         m_dropping;
    int         m_pos;
    int         m_len;
    logic [7:0] m_x;

    task automatic model_reset();
        m_in_pkt   = 1'b0;
        m_dropping = 1'b0;
        m_pos      = 0;
        m_len      = 99;
        m_x        = 8'h00;
    endtask

    // Expected vector: {we, addr[3:0], data[7:0], winc, crc_err, trunc_err, drop}
    task automatic model_step(input bit v, input logic [7:0] b, input bit f,
                              output logic [16:0] e);
        bit         e_we = 1'b0, e_winc = 1'b0, e_crc = 1'b0, e_trunc = 1'b0, e_drop = 1'b0;
        logic [3:0] e_addr = 4'd0;
        logic [7:0] e_data = 8'd0;
        if (m_dropping) begin
            if (!v) m_dropping = 1'b0;
        end else if (!m_in_pkt) begin
            if (v && f) begin
                e_drop     = 1'b1;
                m_dropping = 1'b1;
            end else if (v) begin
                e_we     = 1'b1;
                e_addr   = 4'd0;
                e_data   = b;
                m_x      = b;
                m_pos    = 1;
                m_len    = 99;
                m_in_pkt = 1'b1;
            end
        end else if (!v) begin
            e_trunc  = 1'b1;
            m_in_pkt = 1'b0;
        end else begin
            e_we   = 1'b1;
            e_addr = 4'(m_pos);
            e_data = b;
            if (m_pos == 2) m_len = 3 + int'(b[2:0]) + 1 + 1;
            if (m_pos == m_len - 1) begin
                if (b == m_x) e_winc = 1'b1;
                else          e_crc  = 1'b1;
                m_in_pkt = 1'b0;
            end else begin
                m_x = m_x ^ b;
            end
            m_pos++;
        end
        e = {e_we, e_addr, e_data, e_winc, e_crc, e_trunc, e_drop};
    endtask

    task automatic cyc(input bit v, input logic [7:0] b, input bit f,
                       output logic [16:0] o, output logic [16:0] e);
        packet_valid = v;
        packet_in    = b;
        wfull        = f;
        model_step(v, b, f, e);
        @(posedge clk);
        #1;
        o = {we, we ? waddr_out : 4'd0, we ? wdata : 8'd0, winc, crc_err, trunc_err, drop};
    endtask

    task automatic test_reset();
        logic [16:0] o;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        o = {we, waddr_out, wdata, winc, crc_err, trunc_err, drop};
        checks++;
        if (o !== 17'd0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", o, 17'd0);
        end
        for (int i = 0; i < 3; i++) begin
            packet_valid = 1'b1;
            packet_in    = 8'($urandom);
            @(posedge clk);
            #1;
            o = {we, waddr_out, wdata, winc, crc_err, trunc_err, drop};
            checks++;
            if (o !== 17'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, o, 17'd0);
            end
        end
        packet_valid = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h55, 8'hFD};
        int n_winc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            n_winc += int'(o[3]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL basic cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (n_winc !== 1) begin
            failures++;
            $display("FAIL basic_winc_count got=%0d exp=1", n_winc);
        end
    endtask

    task automatic test_crc_error();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h55, 8'hFE};
        int n_err = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            n_err += int'(o[2]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL crc_err cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (n_err !== 1) begin
            failures++;
            $display("FAIL crc_err_count got=%0d exp=1", n_err);
        end
    endtask

    task automatic test_max_packet();
        logic [16:0] o, e;
        logic [7:0]  pk[$];
        logic [7:0]  crc;
        int max_addr = 0;
        pk = '{8'h11, 8'h22, 8'hF7};
        for (int j = 0; j < 8; j++) pk.push_back(8'($urandom));
        crc = 8'h00;
        foreach (pk[j]) crc ^= pk[j];
        pk.push_back(crc);
        for (int i = 0; i < 14; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            if (o[16] && int'(o[15:12]) > max_addr) max_addr = int'(o[15:12]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL max_pkt cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (max_addr !== 11) begin
            failures++;
            $display("FAIL max_pkt_last_addr got=%0d exp=11", max_addr);
        end
    endtask

    task automatic test_truncate();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01};
        for (int i = 0; i < 6; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL trunc cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_drop();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h55, 8'hFD};
        int n_we = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], i == 0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            n_we += int'(o[16]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL drop cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (n_we !== 0) begin
            failures++;
            $display("FAIL drop_we_count got=%0d exp=0", n_we);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL drop_next cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h55, 8'hFD,
                               8'h33, 8'h44, 8'h08, 8'h10, 8'h6F};
        int n_winc = 0;
        for (int i = 0; i < 13; i++) begin
            if (i < pk.size()) cyc(1'b1, pk[i], 1'b0, o, e);
            else               cyc(1'b0, 8'h00, 1'b0, o, e);
            n_winc += int'(o[3]);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        checks++;
        if (n_winc !== 2) begin
            failures++;
            $display("FAIL b2b_winc_count got=%0d exp=2", n_winc);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [16:0] o, e;
        logic [7:0]  pk[$] = '{8'h01, 8'h02, 8'h01, 8'hAA, 8'h55, 8'hFD};
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, pk[i], 1'b0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
        rst = 1'b0;
        #1;
        o = {we, waddr_out, wdata, winc, crc_err, trunc_err, drop};
        checks++;
        if (o !== 17'd0) begin
            failures++;
            $display("FAIL rst_mid_async got=%h exp=%h", o, 17'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 9; i++) begin
            if (i >= 1 && i <= pk.size()) cyc(1'b1, pk[i-1], 1'b0, o, e);
            else                          cyc(1'b0, 8'h00, 1'b0, o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rst_mid_post cyc=%0d got=%h exp=%h", i, o, e);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] o, e;
        logic [7:0]  pk[$];
        logic [7:0]  crc;
        int n, k, gap;
        for (int p = 0; p < 150; p++) begin
            pk.delete();
            for (int j = 0; j < 3; j++) pk.push_back(8'($urandom));
            n = int'(pk[2][2:0]) + 1;
            for (int j = 0; j < n; j++) pk.push_back(8'($urandom));
            crc = 8'h00;
            foreach (pk[j]) crc ^= pk[j];
            if ($urandom_range(0, 3) == 0) crc ^= 8'($urandom_range(1, 255));
            pk.push_back(crc);
            k = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, pk.size() - 1)) : pk.size();
            gap = int'($urandom_range(0, 2)) + ((k < pk.size()) ? 1 : 0);
            for (int j = 0; j < k + gap; j++) begin
                if (j < k) cyc(1'b1, pk[j], $urandom_range(0, 7) == 0, o, e);
                else       cyc(1'b0, 8'($urandom), $urandom_range(0, 7) == 0, o, e);
                checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL random pkt=%0d byte=%0d got=%h exp=%h", p, j, o, e);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_crc_error();
        test_max_packet();
        test_truncate();
        test_drop();
        test_back_to_back();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
